ap_ctrl_launcher: RTL and testbench

Synthesizable ap_ctrl_hs/ap_ctrl_chain initiator that drives the block-level handshake of an HLS kernel (e.g. `mmult` or one of its pipeline sub-functions) in place of a testbench or host sequencer. It issues a commanded number of invocations and tracks overlapping invocations up to a configurable depth. It reports per-invocation start-to-done latency as a result stream, plus a run-complete pulse. It is the driving counterpart to the passive module-status monitors.

---
 rtl/ap_ctrl_launcher_pkg.sv | 14 +
 rtl/ap_ctrl_launcher_if.sv | 34 +++
 rtl/ap_ctrl_launcher_ts_fifo.sv | 58 +++++
 rtl/ap_ctrl_launcher.sv | 151 +++++++++++++++
 tb/tb_ap_ctrl_launcher.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/ap_ctrl_launcher_pkg.sv
// Shared types and default widths for the ap_ctrl_hs/ap_ctrl_chain launcher.
package ap_ctrl_pkg;

   localparam int CNT_W_DEF = 16;
   localparam int TS_W_DEF  = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } launcher_state_t;

endpackage

// File: rtl/ap_ctrl_launcher_if.sv
// Command, kernel block-level handshake and result stream of the launcher.
interface ap_ctrl_launcher_if import ap_ctrl_pkg::*; #(
   parameter int CNT_W = CNT_W_DEF,
   parameter int TS_W  = TS_W_DEF
) ();

   logic             cmd_valid;
   logic             cmd_ready;
   logic [CNT_W-1:0] cmd_count;
   logic             cont_en;
   logic             ap_start;
   logic             ap_ready;
   logic             ap_done;
   logic             ap_continue;
   logic             res_valid;
   logic [CNT_W-1:0] res_index;
   logic [TS_W-1:0]  res_latency;
   logic             run_done;
   logic             busy;
   logic             err;

   modport master (
      input  cmd_valid, cmd_count, cont_en, ap_ready, ap_done,
      output cmd_ready, ap_start, ap_continue, res_valid, res_index,
             res_latency, run_done, busy, err
   );

   modport slave (
      output cmd_valid, cmd_count, cont_en, ap_ready, ap_done,
      input  cmd_ready, ap_start, ap_continue, res_valid, res_index,
             res_latency, run_done, busy, err
   );

endinterface

// File: rtl/ap_ctrl_launcher_ts_fifo.sv
// Start-timestamp FIFO: one entry per outstanding invocation, same-cycle push/pop.
module ts_fifo #(
   parameter int  W     = 32,
   parameter int  DEPTH = 4,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          i_push,
   input  logic [W-1:0]  i_din,
   input  logic          i_pop,
   output logic [W-1:0]  o_dout,
   output logic          o_full,
   output logic          o_empty,
   output logic [CW-1:0] o_count
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   function automatic logic [AW-1:0] ptr_nxt(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CW'(DEPTH));
   assign o_count   = r_count;
   assign o_dout    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   // A pop in the same cycle frees the slot a full push needs.
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
            r_wr_ptr        <= ptr_nxt(r_wr_ptr);
         end
         if (w_do_pop) r_rd_ptr <= ptr_nxt(r_rd_ptr);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ap_ctrl_launcher.sv
// Drives an HLS kernel's ap_ctrl handshake for a commanded number of invocations
// and reports per-invocation start-to-done latency.
module ap_ctrl_launcher import ap_ctrl_pkg::*; #(
   parameter int CNT_W = CNT_W_DEF,
   parameter int TS_W  = TS_W_DEF,
   parameter int DEPTH = 4
) (
   input logic                clock,
   input logic                reset,
   ap_ctrl_launcher_if.master bus
);

   localparam int OCC_W = $clog2(DEPTH) + 1;

   launcher_state_t  r_state;
   logic             r_cmd_ready;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_issued;
   logic [CNT_W-1:0] r_completed;
   logic [TS_W-1:0]  r_cyc;
   logic [TS_W-1:0]  r_start_ts;
   logic             r_start_armed;
   logic             r_res_valid;
   logic [CNT_W-1:0] r_res_index;
   logic [TS_W-1:0]  r_res_latency;
   logic             r_err;

   logic             w_active;
   logic             w_ap_start;
   logic             w_ap_continue;
   logic             w_launch;
   logic             w_done_acc;
   logic             w_cmp;
   logic             w_spur;
   logic             w_bypass;
   logic             w_push;
   logic             w_pop;
   logic [TS_W-1:0]  w_cur_ts;
   logic [TS_W-1:0]  w_head_ts;
   logic [TS_W-1:0]  w_fifo_dout;
   logic             w_full;
   logic             w_empty;
   logic [OCC_W-1:0] w_occ;
   logic [CNT_W-1:0] w_issued_nxt;
   logic [CNT_W-1:0] w_completed_nxt;

   assign w_active      = (r_state == RUN) || (r_state == DRAIN);
   assign w_ap_start    = (r_state == RUN) && (r_issued < r_count) && (w_occ < OCC_W'(DEPTH));
   assign w_ap_continue = w_active && bus.cont_en;
   assign w_launch      = w_ap_start && bus.ap_ready;

   // Outside RUN/DRAIN nothing can be outstanding, so any ap_done there is spurious.
   assign w_done_acc = bus.ap_done && (w_ap_continue || !w_active);
   assign w_bypass   = w_done_acc && w_empty && w_launch;
   assign w_cmp      = w_done_acc && (!w_empty || w_launch);
   assign w_spur     = w_done_acc && w_empty && !w_launch;

   // Start timestamp is held from the first cycle ap_start rose for this invocation.
   assign w_cur_ts  = r_start_armed ? r_start_ts : r_cyc;
   assign w_head_ts = w_empty ? w_cur_ts : w_fifo_dout;
   assign w_push    = w_launch && !w_bypass && !w_full;
   assign w_pop     = w_cmp && !w_empty;

   assign w_issued_nxt    = r_issued + 1'b1;
   assign w_completed_nxt = r_completed + CNT_W'(w_cmp);

   ts_fifo #(.W(TS_W), .DEPTH(DEPTH)) u_ts_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (w_push),
      .i_din   (w_cur_ts),
      .i_pop   (w_pop),
      .o_dout  (w_fifo_dout),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_occ)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= IDLE;
         r_cmd_ready   <= 1'b0;
         r_count       <= '0;
         r_issued      <= '0;
         r_completed   <= '0;
         r_cyc         <= '0;
         r_start_ts    <= '0;
         r_start_armed <= 1'b0;
         r_res_valid   <= 1'b0;
         r_res_index   <= '0;
         r_res_latency <= '0;
         r_err         <= 1'b0;
      end else begin
         r_cyc       <= r_cyc + 1'b1;
         r_res_valid <= w_cmp;
         if (w_cmp) begin
            r_res_index   <= r_completed;
            r_res_latency <= r_cyc - w_head_ts;
         end
         if (w_spur) r_err <= 1'b1;

         if (w_launch) begin
            r_start_armed <= 1'b0;
         end else if (w_ap_start) begin
            r_start_ts    <= w_cur_ts;
            r_start_armed <= 1'b1;
         end

         if (w_launch) r_issued <= w_issued_nxt;
         if (w_cmp) r_completed <= w_completed_nxt;

         case (r_state)
            IDLE: begin
               if (bus.cmd_valid && r_cmd_ready) begin
                  r_count     <= bus.cmd_count;
                  r_issued    <= '0;
                  r_completed <= '0;
                  r_state     <= (bus.cmd_count == '0) ? DONE : RUN;
                  r_cmd_ready <= 1'b0;
               end else begin
                  r_cmd_ready <= 1'b1;
               end
            end
            RUN: begin
               // A final launch whose result bypasses out in the same cycle skips DRAIN.
               if (w_launch && (w_issued_nxt == r_count))
                  r_state <= (w_completed_nxt == r_count) ? DONE : DRAIN;
            end
            DRAIN: begin
               if (w_completed_nxt == r_count) r_state <= DONE;
            end
            DONE: begin
               r_state     <= IDLE;
               r_cmd_ready <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.cmd_ready   = r_cmd_ready;
   assign bus.ap_start    = w_ap_start;
   assign bus.ap_continue = w_ap_continue;
   assign bus.res_valid   = r_res_valid;
   assign bus.res_index   = r_res_index;
   assign bus.res_latency = r_res_latency;
   assign bus.run_done    = (r_state == DONE);
   assign bus.busy        = (r_state != IDLE);
   assign bus.err         = r_err;

endmodule

// File: tb/tb_ap_ctrl_launcher.sv
// Bench for ap_ctrl_launcher: behavioural kernel, result scoreboard, run table.
module tb_ap_ctrl_launcher;
   import ap_ctrl_pkg::*;

   localparam int CNT_W = CNT_W_DEF;
   localparam int TS_W  = TS_W_DEF;
   localparam int DEPTH = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   ap_ctrl_launcher_if #(.CNT_W(CNT_W), .TS_W(TS_W)) bus ();

   ap_ctrl_launcher #(.CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Kernel model: ap_ready immediate, ap_done lat_cfg cycles after start (same cycle if 0).
   int  lat_cfg   = 5;
   bit  spur_done = 1'b0;
   int  tcyc      = 0;
   bit  armed     = 1'b0;
   int  st        = 0;
   int  comp_idx  = 0;
   int  max_out   = 0;
   int  done_q[$];
   int  start_q[$];

   typedef struct {
      int idx;
      int lat;
   } exp_t;
   exp_t exp_q[$];

   assign bus.ap_ready = bus.ap_start;

   always @(posedge clock) begin
      int s;
      if (reset) begin
         done_q.delete();
         start_q.delete();
         exp_q.delete();
         armed = 1'b0;
      end else begin
         if (bus.cmd_valid && bus.cmd_ready) comp_idx = 0;
         if (bus.ap_start && !armed) begin
            st    = tcyc;
            armed = 1'b1;
         end
         if (bus.ap_start && bus.ap_ready) begin
            start_q.push_back(st);
            done_q.push_back(st + lat_cfg);
            armed = 1'b0;
         end
         if (bus.ap_done && bus.ap_continue && start_q.size() != 0) begin
            s = start_q.pop_front();
            void'(done_q.pop_front());
            exp_q.push_back('{comp_idx, tcyc - s});
            comp_idx++;
         end
         if (start_q.size() > max_out) max_out = start_q.size();
      end
      tcyc++;
   end

   always @(negedge clock) begin
      #1;
      bus.ap_done = spur_done || (lat_cfg == 0 && bus.ap_start) ||
                    (done_q.size() != 0 && tcyc >= done_q[0]);
   end

   always @(negedge clock) begin
      exp_t e;
      if (bus.res_valid) begin
         check("sb_pending", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("res_index", bus.res_index, e.idx);
            check("res_latency", bus.res_latency, e.lat);
         end
      end
   end

   typedef struct {
      int count;
      int lat;
      int cont_on;   // cont_en held low before this offset from accept
      int done_off;  // run_done cycle relative to accept
      int nres;
      int lat_exp;
      int max_out;
   } row_t;

   task automatic run_row(input string tag, input row_t r);
      int nres = 0;
      int off  = -1;
      bit seen = 1'b0;
      lat_cfg = r.lat;
      max_out = 0;
      check({tag, ".cmd_ready"}, bus.cmd_ready, 1);
      for (int k = 0; k <= 200; k++) begin
         bus.cont_en   = (k >= r.cont_on);
         bus.cmd_valid = (k == 0);
         bus.cmd_count = CNT_W'(r.count);
         if (k == 1) begin
            check({tag, ".start_rise"}, bus.ap_start, r.count != 0);
            check({tag, ".busy"}, bus.busy, 1);
         end
         if (k >= 1) begin
            if (bus.ap_start) seen = 1'b1;
            if (bus.res_valid) begin
               nres++;
               check({tag, ".lat_const"}, bus.res_latency, r.lat_exp);
            end
            if (bus.run_done) begin
               off = k;
               check({tag, ".res_with_done"}, bus.res_valid, r.count != 0);
               break;
            end
         end
         @(negedge clock);
      end
      bus.cmd_valid = 1'b0;
      check({tag, ".done_off"}, off, r.done_off);
      check({tag, ".nres"}, nres, r.nres);
      check({tag, ".max_out"}, max_out, r.max_out);
      check({tag, ".start_seen"}, seen, r.count != 0);
      check({tag, ".err"}, bus.err, 0);
      @(negedge clock);
      check({tag, ".idle_ready"}, bus.cmd_ready, 1);
      check({tag, ".idle_busy"}, bus.busy, 0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".cmd_ready"}, bus.cmd_ready, 0);
      check({tag, ".ap_start"}, bus.ap_start, 0);
      check({tag, ".ap_continue"}, bus.ap_continue, 0);
      check({tag, ".res_valid"}, bus.res_valid, 0);
      check({tag, ".run_done"}, bus.run_done, 0);
      check({tag, ".busy"}, bus.busy, 0);
      check({tag, ".err"}, bus.err, 0);
      check({tag, ".res_index"}, bus.res_index, 0);
      check({tag, ".res_latency"}, bus.res_latency, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      row_t rows[6];
      rows[0] = '{3, 5, 0, 13, 3, 5, 2};   // depth-limited, latency 5
      rows[1] = '{4, 20, 0, 44, 4, 20, 2}; // stalls at 2 outstanding
      rows[2] = '{1, 5, 10, 11, 1, 9, 1};  // ap_done held until cont_en
      rows[3] = '{2, 0, 0, 3, 2, 0, 0};    // zero-latency kernel: bypass path
      rows[4] = '{0, 5, 0, 1, 0, 0, 0};    // empty run
      rows[5] = '{1, 5, 0, 7, 1, 5, 1};    // after mid-run reset

      bus.cmd_valid = 1'b0;
      bus.cmd_count = '0;
      bus.cont_en   = 1'b0;
      reset         = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check_reset_vals("rst");
      reset = 1'b0;
      @(negedge clock);
      check("rst.ready_after", bus.cmd_ready, 1);

      for (int i = 0; i < 5; i++) run_row($sformatf("row%0d", i), rows[i]);

      // ap_done while idle
      spur_done = 1'b1;
      @(negedge clock);
      spur_done = 1'b0;
      check("spur.err", bus.err, 1);
      check("spur.res_valid", bus.res_valid, 0);
      repeat (3) @(negedge clock);
      check("spur.err_sticky", bus.err, 1);
      check("spur.busy", bus.busy, 0);

      // reset in DRAIN with two outstanding
      lat_cfg       = 20;
      bus.cont_en   = 1'b1;
      bus.cmd_count = CNT_W'(2);
      bus.cmd_valid = 1'b1;
      @(negedge clock);
      bus.cmd_valid = 1'b0;
      repeat (4) @(negedge clock);
      check("drain.busy", bus.busy, 1);
      check("drain.ap_start", bus.ap_start, 0);
      check("drain.outstanding", start_q.size(), 2);
      reset = 1'b1;
      @(negedge clock);
      check_reset_vals("midrst");
      reset = 1'b0;
      @(negedge clock);
      check("midrst.ready_after", bus.cmd_ready, 1);
      run_row("row5", rows[5]);

      repeat (3) @(negedge clock);
      check("sb_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
